// File: rtl/keypad_scanner_pkg.sv
// Shared definitions for the matrix keypad scanner: widths, FSM encodings and
// small helpers for column drive and row selection.
package keypad_scanner_pkg;

   localparam int KEY_CODE_WIDTH = 4;
   localparam int KEYPAD_DIM     = 4;
   localparam logic [KEYPAD_DIM-1:0] COL_IDLE = 4'b1111;

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      PRESS    = 2'd2,
      RELEASE  = 2'd3
   } scan_state_t;

   // Active-low one-hot pattern that drives a single column.
   function automatic logic [KEYPAD_DIM-1:0] colDrive(input logic [1:0] idx);
      colDrive = COL_IDLE & ~(4'b0001 << idx);
   endfunction

   // The lowest-numbered active row wins when several rows read low together.
   function automatic logic [1:0] lowestLow(input logic [KEYPAD_DIM-1:0] rows);
      lowestLow = 2'd0;
      for (int i = KEYPAD_DIM - 1; i >= 0; i--) begin
         if (!rows[i]) lowestLow = 2'(i);
      end
   endfunction

endpackage

// File: rtl/keypad_scanner_sync_2ff.sv
// Two-flop synchronizer for asynchronous board inputs; resets to all ones so
// that idle pulled-up lines read inactive right after reset.
module sync_2ff #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] i_async,
   output logic [WIDTH-1:0] o_sync
);

   logic [WIDTH-1:0] r_meta;
   logic [WIDTH-1:0] r_sync;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_meta <= '1;
         r_sync <= '1;
      end else begin
         r_meta <= i_async;
         r_sync <= r_meta;
      end
   end

   assign o_sync = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: walks the columns, debounces press and release on the
// detected row, and hands one key code per press to the CPU with ready/ack.
module keypad_scanner
   import keypad_scanner_pkg::*;
#(
   parameter int SCAN_DIV        = 1000,
   parameter int DEBOUNCE_CYCLES = 20000
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [KEYPAD_DIM-1:0]     row_in,
   output logic [KEYPAD_DIM-1:0]     col_out,
   input  logic                      key_ack,
   output logic [KEY_CODE_WIDTH-1:0] key_code,
   output logic                      key_ready,
   output logic                      key_overrun,
   output logic                      key_held
);

   localparam int MAX_CNT = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CNT);
   localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

   scan_state_t               r_state;
   logic [1:0]                r_colIdx;
   logic [1:0]                r_rowIdx;
   logic [CNT_W-1:0]          r_scanCnt;
   logic [CNT_W-1:0]          r_debCnt;
   logic [KEYPAD_DIM-1:0]     r_colOut;
   logic [KEY_CODE_WIDTH-1:0] r_keyCode;
   logic                      r_keyReady;
   logic                      r_keyOverrun;
   logic                      r_keyHeld;

   logic [KEYPAD_DIM-1:0]     w_rowSync;
   logic [1:0]                w_nextCol;
   logic                      w_rowHigh;
   logic                      w_anyLow;

   sync_2ff #(.WIDTH(KEYPAD_DIM)) u_rowSync (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_async (row_in),
      .o_sync  (w_rowSync)
   );

   assign w_nextCol = r_colIdx + 2'd1;
   assign w_rowHigh = w_rowSync[r_rowIdx];
   assign w_anyLow  = ~(&w_rowSync);

   // The handshake clear is written first so that a PRESS in the same cycle
   // overrides it: the new key wins and the overrun flag ends up cleared.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= SCAN;
         r_colIdx     <= 2'd0;
         r_rowIdx     <= 2'd0;
         r_scanCnt    <= '0;
         r_debCnt     <= '0;
         r_colOut     <= colDrive(2'd0);
         r_keyCode    <= '0;
         r_keyReady   <= 1'b0;
         r_keyOverrun <= 1'b0;
         r_keyHeld    <= 1'b0;
      end else begin
         if (key_ack && r_keyReady) begin
            r_keyReady   <= 1'b0;
            r_keyOverrun <= 1'b0;
         end
         case (r_state)
            SCAN: begin
               if (r_scanCnt == SCAN_LAST) begin
                  r_scanCnt <= '0;
                  if (w_anyLow) begin
                     r_rowIdx <= lowestLow(w_rowSync);
                     r_debCnt <= '0;
                     r_state  <= DEBOUNCE;
                  end else begin
                     r_colIdx <= w_nextCol;
                     r_colOut <= colDrive(w_nextCol);
                  end
               end else begin
                  r_scanCnt <= r_scanCnt + CNT_W'(1);
               end
            end
            DEBOUNCE: begin
               if (w_rowHigh) begin
                  r_colIdx  <= w_nextCol;
                  r_colOut  <= colDrive(w_nextCol);
                  r_scanCnt <= '0;
                  r_state   <= SCAN;
               end else if (r_debCnt == DEB_LAST) begin
                  r_state <= PRESS;
               end else begin
                  r_debCnt <= r_debCnt + CNT_W'(1);
               end
            end
            PRESS: begin
               if (!r_keyReady || key_ack) begin
                  r_keyCode  <= {r_rowIdx, r_colIdx};
                  r_keyReady <= 1'b1;
               end else begin
                  r_keyOverrun <= 1'b1;
               end
               r_keyHeld <= 1'b1;
               r_debCnt  <= '0;
               r_state   <= RELEASE;
            end
            RELEASE: begin
               if (!w_rowHigh) begin
                  r_debCnt <= '0;
               end else if (r_debCnt == DEB_LAST) begin
                  r_keyHeld <= 1'b0;
                  r_colIdx  <= w_nextCol;
                  r_colOut  <= colDrive(w_nextCol);
                  r_scanCnt <= '0;
                  r_state   <= SCAN;
               end else begin
                  r_debCnt <= r_debCnt + CNT_W'(1);
               end
            end
            default: begin
               r_state <= SCAN;
            end
         endcase
      end
   end

   assign col_out     = r_colOut;
   assign key_code    = r_keyCode;
   assign key_ready   = r_keyReady;
   assign key_overrun = r_keyOverrun;
   assign key_held    = r_keyHeld;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad matrix model feeds the rows, and a
// scoreboard checks every published key event against queued expectations.
module tb_keypad_scanner;

   localparam int SCAN_DIV = 4;
   localparam int DEB      = 8;

   logic       clk     = 1'b0;
   logic       rst_n   = 1'b0;
   logic       key_ack = 1'b0;
   logic [3:0] row_in;
   logic [3:0] col_out;
   logic [3:0] key_code;
   logic       key_ready;
   logic       key_overrun;
   logic       key_held;

   logic [15:0] pressed = '0;
   int          total = 0;
   int          bad   = 0;
   logic [5:0]  expQ[$];
   logic [5:0]  monExp;
   logic        prevHeld = 1'b0;

   keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CYCLES(DEB)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .row_in      (row_in),
      .col_out     (col_out),
      .key_ack     (key_ack),
      .key_code    (key_code),
      .key_ready   (key_ready),
      .key_overrun (key_overrun),
      .key_held    (key_held)
   );

   always #5 clk = ~clk;

   // A pressed key shorts its row to its column only while that column is driven low.
   always_comb begin
      row_in = 4'hF;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (pressed[r*4+c] && col_out[c] == 1'b0) row_in[r] = 1'b0;
         end
      end
   end

   // Every rising edge of key_held marks a PRESS; compare the published state then.
   always @(negedge clk) begin
      if (key_held === 1'b1 && prevHeld !== 1'b1) begin
         total++;
         if (expQ.size() == 0) begin
            bad++;
            $display("[TB] FAIL event: unexpected key event code=%0d ready=%0b ovr=%0b",
                     key_code, key_ready, key_overrun);
         end else begin
            monExp = expQ.pop_front();
            if ({key_code, key_ready, key_overrun} !== monExp) begin
               bad++;
               $display("[TB] FAIL event: got code=%0d ready=%0b ovr=%0b, expected code=%0d ready=%0b ovr=%0b",
                        key_code, key_ready, key_overrun, monExp[5:2], monExp[1], monExp[0]);
            end
         end
      end
      prevHeld = key_held;
   end

   task automatic waitColStart(input logic [3:0] col);
      logic [3:0] prev;
      bit         found;
      prev  = col_out;
      found = 1'b0;
      for (int i = 0; i < 64 && !found; i++) begin
         @(negedge clk);
         if (col_out == col && prev != col) found = 1'b1;
         prev = col_out;
      end
      if (!found) begin
         total++;
         bad++;
         $display("[TB] FAIL col_start: col_out=%b never began, required %b", col_out, col);
      end
   endtask

   task automatic waitHeld(input logic level, output int cycles);
      bit done;
      done   = 1'b0;
      cycles = 0;
      for (int i = 0; i < 300 && !done; i++) begin
         @(negedge clk);
         cycles++;
         if (key_held === level) done = 1'b1;
      end
      if (!done) begin
         total++;
         bad++;
         $display("[TB] FAIL held_wait: key_held=%b, required %b within 300 cycles", key_held, level);
      end
   endtask

   task automatic pressKey(input int code);
      int cyc;
      pressed[code] = 1'b1;
      waitHeld(1'b1, cyc);
      pressed[code] = 1'b0;
      waitHeld(1'b0, cyc);
   endtask

   task automatic pulseAck();
      key_ack = 1'b1;
      @(negedge clk);
      key_ack = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      total++;
      if ({col_out, key_code, key_ready, key_overrun, key_held} !== {4'b1110, 4'd0, 3'b000}) begin
         bad++;
         $display("[TB] FAIL reset: col=%b code=%0d rdy=%b ovr=%b held=%b, required 1110/0/0/0/0",
                  col_out, key_code, key_ready, key_overrun, key_held);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_idle();
      logic [3:0] expCol;
      bit         readySeen;
      readySeen = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         expCol = 4'b1111 & ~(4'b0001 << ((k / SCAN_DIV) % 4));
         total++;
         if (col_out !== expCol) begin
            bad++;
            $display("[TB] FAIL idle_col[%0d]: col_out=%b, required %b", k, col_out, expCol);
         end
         if (key_ready !== 1'b0) readySeen = 1'b1;
      end
      total++;
      if (readySeen) begin
         bad++;
         $display("[TB] FAIL idle_ready: key_ready=1 seen, required 0");
      end
   endtask

   task automatic test_press();
      int cyc;
      expQ.push_back({4'd9, 1'b1, 1'b0});
      pressed[9] = 1'b1;
      waitHeld(1'b1, cyc);
      pressed[9] = 1'b0;
      waitHeld(1'b0, cyc);
      total++;
      if (cyc != DEB + 2) begin
         bad++;
         $display("[TB] FAIL release_latency: %0d cycles, required %0d", cyc, DEB + 2);
      end
      total++;
      if (col_out !== 4'b1011) begin
         bad++;
         $display("[TB] FAIL resume_col: col_out=%b, required 1011", col_out);
      end
      total++;
      if (key_ready !== 1'b1 || key_code !== 4'd9) begin
         bad++;
         $display("[TB] FAIL press_hold: ready=%b code=%0d, required 1/9", key_ready, key_code);
      end
      pulseAck();
      total++;
      if (key_ready !== 1'b0) begin
         bad++;
         $display("[TB] FAIL ack_clear: key_ready=%b, required 0", key_ready);
      end
   endtask

   task automatic test_bounce();
      waitColStart(4'b1110);
      pressed[0] = 1'b1;
      repeat (4) @(negedge clk);
      total++;
      if (col_out !== 4'b1110) begin
         bad++;
         $display("[TB] FAIL bounce_enter: col_out=%b, required 1110", col_out);
      end
      @(negedge clk);
      pressed[0] = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if ({col_out, key_ready, key_held} !== {4'b1101, 2'b00}) begin
         bad++;
         $display("[TB] FAIL bounce_abort: col=%b rdy=%b held=%b, required 1101/0/0",
                  col_out, key_ready, key_held);
      end
   endtask

   task automatic test_overrun();
      expQ.push_back({4'd5, 1'b1, 1'b0});
      pressKey(5);
      expQ.push_back({4'd5, 1'b1, 1'b1});
      pressKey(15);
      total++;
      if ({key_code, key_ready, key_overrun} !== {4'd5, 2'b11}) begin
         bad++;
         $display("[TB] FAIL overrun: code=%0d rdy=%b ovr=%b, required 5/1/1",
                  key_code, key_ready, key_overrun);
      end
      pulseAck();
      total++;
      if ({key_ready, key_overrun} !== 2'b00) begin
         bad++;
         $display("[TB] FAIL overrun_ack: rdy=%b ovr=%b, required 0/0", key_ready, key_overrun);
      end
   endtask

   task automatic test_back_to_back();
      int cyc;
      expQ.push_back({4'd6, 1'b1, 1'b0});
      pressKey(6);
      expQ.push_back({4'd6, 1'b1, 1'b1});
      pressKey(10);
      expQ.push_back({4'd3, 1'b1, 1'b0});
      waitColStart(4'b0111);
      pressed[3] = 1'b1;
      repeat (12) @(negedge clk);
      pulseAck();
      total++;
      if ({key_code, key_ready, key_overrun, key_held} !== {4'd3, 3'b101}) begin
         bad++;
         $display("[TB] FAIL ack_press: code=%0d rdy=%b ovr=%b held=%b, required 3/1/0/1",
                  key_code, key_ready, key_overrun, key_held);
      end
      pressed[3] = 1'b0;
      waitHeld(1'b0, cyc);
   endtask

   task automatic test_mid_reset();
      bit stale;
      waitColStart(4'b1101);
      pressed[1] = 1'b1;
      repeat (6) @(negedge clk);
      total++;
      if (col_out !== 4'b1101) begin
         bad++;
         $display("[TB] FAIL mid_debounce: col_out=%b, required 1101", col_out);
      end
      rst_n = 1'b0;
      @(negedge clk);
      total++;
      if ({col_out, key_code, key_ready, key_overrun, key_held} !== {4'b1110, 4'd0, 3'b000}) begin
         bad++;
         $display("[TB] FAIL mid_reset: col=%b code=%0d rdy=%b ovr=%b held=%b, required 1110/0/0/0/0",
                  col_out, key_code, key_ready, key_overrun, key_held);
      end
      pressed[1] = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      stale = 1'b0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (key_ready !== 1'b0 || key_held !== 1'b0) stale = 1'b1;
      end
      total++;
      if (stale) begin
         bad++;
         $display("[TB] FAIL stale_event: rdy/held went high after reset, required 0");
      end
   endtask

   initial begin
      $display("[TB] keypad_scanner bench start");
      test_reset();
      test_idle();
      test_press();
      test_bounce();
      test_overrun();
      test_back_to_back();
      test_mid_reset();
      total++;
      if (expQ.size() != 0) begin
         bad++;
         $display("[TB] FAIL scoreboard: %0d events missing, required 0", expQ.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Scans the 4x4 matrix keypad on the CPU top-level pins `row_in` and `col_out`, debounces key presses, and presents a key code to the CPU I/O path.
- Sits directly upstream of the pipelined CPU core's memory-mapped input; the core reads `key_code` and pulses `key_ack` on the load.
- One key event is produced per press; release must be seen before the next event.

Parameters:
- SCAN_DIV, 1000: clock cycles each column is driven; legal minimum 3.
- DEBOUNCE_CYCLES, 20000: consecutive stable cycles needed to accept a press or a release; legal minimum 2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- row_in  in  4  keypad rows, active-low, externally pulled up
- col_out  out  4  keypad column drive, one-hot active-low
- key_ack  in  1  one-cycle pulse from CPU: current key consumed
- key_code  out  4  row_idx*4 + col_idx of last accepted key
- key_ready  out  1  level; new unconsumed key available
- key_overrun  out  1  sticky; a press was dropped while `key_ready`=1
- key_held  out  1  level; a debounced key is currently down

Behaviour:
- Reset (synchronous, `rst_n`=0 at posedge):
  - state=SCAN, col_idx=0, `col_out`=4'b1110, all counters 0.
  - `key_code`=0, `key_ready`=0, `key_overrun`=0, `key_held`=0, synchronizer flops = 4'b1111.
  - Reset mid-debounce or mid-release aborts with no key published.
- `row_in` passes through a 2-flop synchronizer (row_s); all decisions use row_s only (2-cycle latency).
- SCAN:
  - Drive col_idx low for SCAN_DIV cycles.
  - On dwell count == SCAN_DIV-1, sample row_s.
    - If any bit is 0: latch row_idx = lowest-index low row, hold `col_out`, go DEBOUNCE with deb_cnt=0.
    - Else: col_idx = col_idx+1 mod 4 (3 wraps to 0), dwell count reset.
- DEBOUNCE:
  - Each cycle row_s[row_idx]==0 increments deb_cnt.
  - row_s[row_idx]==1 at any cycle: abort to SCAN at col_idx+1, no event.
  - deb_cnt reaching DEBOUNCE_CYCLES-1 with row still low: go PRESS.
- PRESS (exactly 1 cycle):
  - If `key_ready`=0, or `key_ack`=1 this cycle: `key_code`<=row_idx*4+col_idx, `key_ready`<=1.
  - Else: `key_code` unchanged, `key_overrun`<=1.
  - `key_held`<=1; go RELEASE with deb_cnt=0.
- RELEASE:
  - Column stays driven.
  - deb_cnt counts consecutive cycles with row_s[row_idx]==1; any low cycle clears deb_cnt.
  - On reaching DEBOUNCE_CYCLES-1: `key_held`<=0, go SCAN at col_idx+1.
  - A second key pressed in another row or column while held is ignored.
- Handshake:
  - `key_ack` with `key_ready`=1 clears `key_ready` and `key_overrun` next cycle.
  - `key_ack` with `key_ready`=0 has no effect.
  - Simultaneous PRESS and `key_ack`: the new key wins (`key_ready` stays 1, new code, `key_overrun` cleared, not set).
- Outputs are registered; no combinational path from `row_in` or `key_ack` to any output.
- Counters are sized $clog2(max(SCAN_DIV, DEBOUNCE_CYCLES)) bits; no wrap beyond terminal counts.

Decomposition:
- Shared definitions file (alongside the existing defines): KEY_CODE_WIDTH=4, KEYPAD_DIM=4, state encodings SCAN/DEBOUNCE/PRESS/RELEASE (2 bits), `COL_IDLE`=4'b1111.
- One natural sub-module: sync_2ff, a parameterised-width 2-flop synchronizer with `rst_n` preset to 1s. Reused for other asynchronous board inputs.
- The FSM, scan counter and debounce counter live in keypad_scanner.

Test Plan (SCAN_DIV=4, DEBOUNCE_CYCLES=8):
- Reset then idle (`row_in`=4'hF) -> `col_out` cycles 1110,1101,1011,0111 every 4 clk and wraps; `key_ready`=0 throughout.
- Hold row 2 low whenever col 1 is driven, stable -> after debounce, `key_code`=4'd9, `key_ready`=1, `key_held`=1; release -> `key_held`=0 after 8 stable high cycles; scan resumes at col 2.
- Bounce: row 0 low for 3 cycles during DEBOUNCE, then high -> no event, `key_ready`=0, scan resumes at next column.
- Two presses (code 5 then code 15) without `key_ack` -> `key_code`=5, `key_overrun`=1; `key_ack` -> `key_ready`=0, `key_overrun`=0.
- `key_ack` asserted in the same cycle as PRESS of code 3 while a prior key is pending -> `key_ready`=1, `key_code`=3, `key_overrun`=0.
- Assert `rst_n`=0 mid-DEBOUNCE with key held -> next cycle `col_out`=1110, all outputs 0, no stale event after reset release.
